// File: rtl/xillybus_stream_hub_pkg.sv
// Shared definitions for the Xillybus stream hub.
// Contents:
//   DEF_*        default parameter values for the hub and its FIFOs
//   eof_state_t  state encoding of the read-channel end-of-frame FSM
//   clog2        pointer-width helper usable in constant expressions
package xillybus_hub_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_N_WR  = 2;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        EOF_IDLE  = 2'd0,
        EOF_COUNT = 2'd1,
        EOF_SENT  = 2'd2
    } eof_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/xillybus_stream_hub_fifo.sv
// stream_fifo: generic synchronous FIFO with first-word-fall-through output.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   flush        empties the FIFO at the next edge (wins over push/pop)
//   push         write request; ignored while full
//   push_data    word written on an accepted push
//   pop          read request; ignored while empty
//   head         oldest stored word, forced to zero while empty
//   count        number of stored words, 0..DEPTH
module stream_fifo
    import xillybus_hub_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          head,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);

    // Storage carries no reset; head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/xillybus_stream_hub.sv
// xillybus_stream_hub: buffering hub between Xillybus FIFO ports and the core.
// Ports:
//   bus_clk, bus_rst        clock, asynchronous active-high reset
//   wr_wren/wr_data/wr_open host write channels (N_WR of them), wr_full back-pressure
//   m_valid/m_data/m_ready  core-side drain of each write channel (FWFT)
//   s_valid/s_data/s_ready  core results into the read FIFO
//   rd_rden/rd_data/rd_empty host read channel, rd_data registered
//   rd_eof/rd_open          end-of-frame flag and read file open
//   cfg_frame_len           words per read frame, 0 disables EOF
//   status_ovf              sticky per-channel drop flags
//   dbg_eof_state           current state of the EOF FSM
//
// Handshake: on m_* and s_* a word moves on every rising edge where valid and
// ready are both high; valid never waits for ready, and a producer keeps its
// word stable until it is taken. wr_wren/rd_rden are Xillybus strobes and act
// only when the FIFO can accept or supply a word.
module xillybus_stream_hub
    import xillybus_hub_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N_WR  = DEF_N_WR,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              bus_clk,
    input  logic              bus_rst,
    input  logic [N_WR-1:0]   wr_wren,
    input  logic [N_WR*W-1:0] wr_data,
    input  logic [N_WR-1:0]   wr_open,
    output logic [N_WR-1:0]   wr_full,
    output logic [N_WR-1:0]   m_valid,
    output logic [N_WR*W-1:0] m_data,
    input  logic [N_WR-1:0]   m_ready,
    input  logic              s_valid,
    input  logic [W-1:0]      s_data,
    output logic              s_ready,
    input  logic              rd_rden,
    output logic [W-1:0]      rd_data,
    output logic              rd_empty,
    output logic              rd_eof,
    input  logic              rd_open,
    input  logic [CNT_W-1:0]  cfg_frame_len,
    output logic [N_WR-1:0]   status_ovf,
    output eof_state_t        dbg_eof_state
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]      wr_count [N_WR];
    logic [N_WR-1:0]  wr_open_q;
    logic [AW:0]      rd_count;
    logic [W-1:0]     rd_head;
    logic             rd_pop;
    logic [CNT_W-1:0] sent_cnt;
    eof_state_t       eof_state;

    // Write channels: a closed channel is held flushed.
    for (genvar i = 0; i < N_WR; i++) begin : g_wr
        stream_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk       (bus_clk),
            .rst       (bus_rst),
            .flush     (!wr_open[i]),
            .push      (wr_wren[i] && wr_open[i]),
            .push_data (wr_data[i*W +: W]),
            .pop       (m_ready[i]),
            .head      (m_data[i*W +: W]),
            .count     (wr_count[i])
        );
        assign wr_full[i] = (wr_count[i] == FULL_CNT);
        assign m_valid[i] = (wr_count[i] != '0);
    end

    // Drops set the flag; a reopen clears it. A drop cannot coincide with a
    // reopen because the channel is empty after being closed.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            wr_open_q  <= '0;
            status_ovf <= '0;
        end else begin
            wr_open_q  <= wr_open;
            status_ovf <= (status_ovf & ~(wr_open & ~wr_open_q))
                        | (wr_wren & (~wr_open | wr_full));
        end
    end

    // Read path. s_ready is masked during reset so the core sees no credit.
    assign s_ready  = rd_open && !bus_rst && (rd_count != FULL_CNT);
    assign rd_empty = (rd_count == '0);
    assign rd_pop   = rd_rden && rd_open && !rd_empty;

    stream_fifo #(.W(W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk       (bus_clk),
        .rst       (bus_rst),
        .flush     (!rd_open),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (rd_pop),
        .head      (rd_head),
        .count     (rd_count)
    );

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst)     rd_data <= '0;
        else if (rd_pop) rd_data <= rd_head;
    end

    // EOF FSM: counts words handed to the host; EOF latches once the whole
    // frame has been read and nothing is left buffered, until the file closes.
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            eof_state <= EOF_IDLE;
            sent_cnt  <= '0;
            rd_eof    <= 1'b0;
        end else if (!rd_open) begin
            eof_state <= EOF_IDLE;
            sent_cnt  <= '0;
            rd_eof    <= 1'b0;
        end else begin
            if (rd_pop) sent_cnt <= sent_cnt + 1'b1;
            case (eof_state)
                EOF_IDLE: eof_state <= EOF_COUNT;
                EOF_COUNT: begin
                    if ((cfg_frame_len != '0) && (sent_cnt == cfg_frame_len) && rd_empty) begin
                        eof_state <= EOF_SENT;
                        rd_eof    <= 1'b1;
                    end
                end
                EOF_SENT: rd_eof <= 1'b1;
                default:  eof_state <= EOF_IDLE;
            endcase
        end
    end

    assign dbg_eof_state = eof_state;

endmodule
